// File: rtl/fwht_pkg.sv
// Shared types and defaults for the FWHT frame sequencer and its output framer.
package fwht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_LOG2N   = 3;
  localparam int unsigned DEF_LAT     = 3;
  localparam int unsigned DEF_GAP     = 2;
  localparam int unsigned FRAME_CNT_W = 16;

  // Bits needed to count 0..max_val-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/fwht_out_framer.sv
// Output framing for the FWHT pipeline: start-pulse delay line, N-cycle window,
// registered m_* stream and completed-frame counter.
module fwht_out_framer
  import fwht_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOG2N = DEF_LOG2N,
  parameter int unsigned LAT   = DEF_LAT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       pipe_data,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_first,
  output logic                   m_last,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

  localparam int unsigned N = 2 ** LOG2N;

  logic [LAT-1:0]   dly;
  logic [LOG2N-1:0] out_cnt;
  logic             active;
  logic             win_open;
  logic             win_end;

  assign win_open = dly[LAT-1];
  assign win_end  = (out_cnt == LOG2N'(N - 1));

  // An abort clears any in-flight start pulse and an open window in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dly         <= '0;
      out_cnt     <= '0;
      active      <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_first     <= 1'b0;
      m_last      <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      if (m_last) begin
        o_frame_cnt <= o_frame_cnt + FRAME_CNT_W'(1);
      end
      if (abort) begin
        dly     <= '0;
        out_cnt <= '0;
        active  <= 1'b0;
      end else begin
        dly <= (dly << 1) | LAT'(start);
        if (win_open || active) begin
          m_valid <= 1'b1;
          m_data  <= pipe_data;
          m_first <= win_open;
          m_last  <= win_end;
          out_cnt <= out_cnt + LOG2N'(1);
          active  <= !win_end;
        end
      end
    end
  end

endmodule

// File: rtl/fwht_frame_ctrl.sv
// Frame sequencer for the streaming FWHT pipeline: input FSM (IDLE/RUN/FLUSH/GAP)
// driving the pipeline clock-enable, plus the output framer.
module fwht_frame_ctrl
  import fwht_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOG2N = DEF_LOG2N,
  parameter int unsigned LAT   = DEF_LAT,
  parameter int unsigned GAP   = DEF_GAP
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic                   o_pipe_ce,
  output logic [WIDTH-1:0]       o_pipe_data,
  input  logic [WIDTH-1:0]       i_pipe_data,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_first,
  output logic                   m_last,
  output logic                   o_busy,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic [1:0]             o_err
);

  localparam int unsigned N     = 2 ** LOG2N;
  localparam int unsigned TMR_W = cnt_width((LAT > GAP) ? LAT : GAP);

  state_t           state;
  logic [LOG2N-1:0] in_cnt;
  logic [TMR_W-1:0] tmr;
  logic             last_slot;
  logic             start;
  logic             abort;

  assign last_slot = (in_cnt == LOG2N'(N - 1));
  assign start     = (state == ST_IDLE) && s_valid;
  assign abort     = (state == ST_RUN) && !s_valid;

  // Pipeline drive follows the state directly so the accepting cycle feeds stage 0.
  always_comb begin
    o_pipe_ce   = 1'b0;
    o_pipe_data = '0;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        o_pipe_ce   = s_valid;
        o_pipe_data = s_valid ? s_data : '0;
      end
      ST_FLUSH: o_pipe_ce = 1'b1;
      ST_GAP:   o_pipe_ce = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      s_ready <= 1'b1;
      o_busy  <= 1'b0;
      in_cnt  <= '0;
      tmr     <= '0;
      o_err   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s_valid) begin
            state  <= ST_RUN;
            o_busy <= 1'b1;
            in_cnt <= LOG2N'(1);
            if (s_last != last_slot) o_err[1] <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!s_valid) begin
            state    <= ST_GAP;
            s_ready  <= 1'b0;
            in_cnt   <= '0;
            tmr      <= '0;
            o_err[0] <= 1'b1;
          end else begin
            // in_cnt alone decides the frame end; s_last only flags a mismatch.
            if (s_last != last_slot) o_err[1] <= 1'b1;
            in_cnt <= in_cnt + LOG2N'(1);
            if (last_slot) begin
              state   <= ST_FLUSH;
              s_ready <= 1'b0;
              tmr     <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (tmr == TMR_W'(LAT - 1)) begin
            state <= ST_GAP;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (tmr == TMR_W'(GAP - 1)) begin
            state   <= ST_IDLE;
            s_ready <= 1'b1;
            o_busy  <= 1'b0;
            tmr     <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
      endcase
    end
  end

  fwht_out_framer #(
    .WIDTH(WIDTH),
    .LOG2N(LOG2N),
    .LAT  (LAT)
  ) u_framer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .start      (start),
    .abort      (abort),
    .pipe_data  (i_pipe_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_first    (m_first),
    .m_last     (m_last),
    .o_frame_cnt(o_frame_cnt)
  );

endmodule
